lfsr_uart_tx: RTL and testbench

Downstream consumer of the `pseudo` LFSR generator. It watches the generator's `num`/`busy` pair and captures each finished 8-bit result. Captured results are buffered in a small FIFO and shifted out LSB-first as 8N1 serial frames on one output pin. This gives the Caravel user project a readable result stream without polling the parallel bus.

---
 rtl/lfsr_uart_tx.sv | 145 ++++++++++++++
 tb/tb_lfsr_uart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_uart_tx.sv
// Captures finished LFSR results on busy falling edges, buffers them in a small FIFO,
// and transmits each one LSB-first as an 8N1 serial frame.
module lfsr_uart_tx #(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [DWIDTH-1:0]        num_in,
  input  logic                     busy_in,
  output logic                     tx,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_busy_d;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [DWIDTH-1:0]   r_mem [DEPTH];
  logic [DWIDTH-1:0]   r_shift;
  logic [DWIDTH-1:0]   w_shift_next;
  logic [BAUD_W-1:0]   r_baud;
  logic [BAUD_W-1:0]   w_baud_next;
  logic [BIT_W-1:0]    r_bit;
  logic [BIT_W-1:0]    w_bit_next;
  logic                r_tx;
  logic                w_tx_next;
  logic                r_tx_busy;
  logic                w_tx_busy_next;
  logic                r_overflow;
  logic                w_cap;
  logic                w_pop;
  logic                w_push;
  logic                w_baud_done;
  logic                w_last_bit;

  assign w_cap       = r_busy_d & ~busy_in;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push      = w_cap && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_last_bit  = (r_bit == BIT_W'(DWIDTH - 1));

  assign tx         = r_tx;
  assign tx_busy    = r_tx_busy;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  // Edge detect, FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_busy_d   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_busy_d <= busy_in;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_cap && !w_push) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= num_in;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_pop)                      w_state_next = S_START;
      S_START: if (w_baud_done)                w_state_next = S_DATA;
      S_DATA:  if (w_baud_done && w_last_bit)  w_state_next = S_STOP;
      S_STOP:  if (w_baud_done)                w_state_next = S_IDLE;
      default:                                 w_state_next = S_IDLE;
    endcase
  end

  // Datapath next values; tx is derived from the next state so the pin is registered.
  always_comb begin
    w_shift_next   = r_shift;
    w_baud_next    = r_baud;
    w_bit_next     = r_bit;
    w_tx_next      = 1'b1;
    w_tx_busy_next = (w_state_next != S_IDLE);
    if (r_state == S_IDLE) begin
      if (w_pop) begin
        w_shift_next = r_mem[r_rd_ptr];
        w_baud_next  = '0;
      end
    end else begin
      w_baud_next = w_baud_done ? '0 : r_baud + BAUD_W'(1);
    end
    if ((r_state == S_START) && w_baud_done) w_bit_next = '0;
    if ((r_state == S_DATA) && w_baud_done) begin
      w_shift_next = r_shift >> 1;
      if (!w_last_bit) w_bit_next = r_bit + BIT_W'(1);
    end
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_shift   <= '0;
      r_baud    <= '0;
      r_bit     <= '0;
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
    end else begin
      r_shift   <= w_shift_next;
      r_baud    <= w_baud_next;
      r_bit     <= w_bit_next;
      r_tx      <= w_tx_next;
      r_tx_busy <= w_tx_busy_next;
    end
  end

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// Bench for lfsr_uart_tx: queue/timeline reference model checked every cycle,
// a serial-line monitor, directed timing table and randomized capture traffic.
module tb_lfsr_uart_tx;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CPB   = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          FRAME = (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] num_in = '0;
  logic          busy_in = 1'b0;
  logic          tx;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  lfsr_uart_tx #(.DWIDTH(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .num_in     (num_in),
    .busy_in    (busy_in),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending queue plus the start cycle of the frame on the line.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_sent[$];
  logic [DW-1:0] m_cur = '0;
  int            m_cyc = 0;
  int            m_start = -4 * FRAME;
  logic          m_busy_d = 1'b0;
  logic          m_ovf = 1'b0;
  int            peak = 0;

  // Line monitor state.
  bit            mon_active = 0;
  int            mon_off = 0;
  logic [DW-1:0] mon_byte = '0;
  logic [DW-1:0] rx[$];
  logic [DW-1:0] exp_rx[$];

  typedef struct {
    int   rel;
    logic tx;
    logic busy;
    int   cnt;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  function automatic bit m_active(input int n);
    return (n >= m_start) && (n < m_start + FRAME);
  endfunction

  function automatic logic exp_tx();
    int b;
    if (!m_active(m_cyc)) return 1'b1;
    b = (m_cyc - m_start) / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sent.delete();
    m_start    = m_cyc - 4 * FRAME;
    m_busy_d   = 1'b0;
    m_ovf      = 1'b0;
    mon_active = 0;
    rx.delete();
  endtask

  task automatic mon(input logic t);
    int idx;
    if (!mon_active) begin
      if (t == 1'b0) begin
        mon_active = 1;
        mon_off    = 0;
      end
    end else begin
      mon_off++;
      if ((mon_off % CPB) == CPB / 2) begin
        idx = mon_off / CPB;
        if (idx == 0) chk("start_bit", 32'(t), 32'd0);
        else if (idx <= DW) mon_byte[idx-1] = t;
        else begin
          chk("stop_bit", 32'(t), 32'd1);
          rx.push_back(mon_byte);
          mon_active = 0;
        end
      end
    end
  endtask

  // One clock: advance the model with the inputs of this cycle, then compare next cycle.
  task automatic step();
    logic cap;
    logic pop;
    cap = m_busy_d && !busy_in;
    pop = !m_active(m_cyc) && (m_q.size() != 0);
    if (pop) begin
      m_cur   = m_q.pop_front();
      m_start = m_cyc + 1;
      m_sent.push_back(m_cur);
    end
    if (cap) begin
      if (m_q.size() < DEPTH) m_q.push_back(num_in);
      else                    m_ovf = 1'b1;
    end
    m_busy_d = busy_in;
    @(posedge clk);
    #1;
    m_cyc++;
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("tx_busy", 32'(tx_busy), 32'(m_active(m_cyc)));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
    mon(tx);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    busy_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_cyc += 3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cap_byte(input logic [DW-1:0] v);
    busy_in = 1'b1;
    step();
    num_in  = v;
    busy_in = 1'b0;
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    busy_in = 1'b1;
    while ((m_q.size() != 0 || m_active(m_cyc) || mon_active) && n < 20 * FRAME) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 20 * FRAME), 32'd1);
    repeat (3) step();
  endtask

  task automatic check_rx(input string name);
    int n;
    chk({name, "_rx_count"}, 32'(rx.size()), 32'(exp_rx.size()));
    n = (rx.size() < exp_rx.size()) ? rx.size() : exp_rx.size();
    for (int i = 0; i < n; i++) chk({name, "_rx_byte"}, 32'(rx[i]), 32'(exp_rx[i]));
    rx.delete();
    exp_rx.delete();
  endtask

  initial begin
    int n;
    logic [DW-1:0] v;

    tbl[0]  = '{1,   1'b1, 1'b0, 1};
    tbl[1]  = '{2,   1'b0, 1'b1, 0};
    tbl[2]  = '{17,  1'b0, 1'b1, 0};
    tbl[3]  = '{18,  1'b1, 1'b1, 0};
    tbl[4]  = '{34,  1'b0, 1'b1, 0};
    tbl[5]  = '{50,  1'b1, 1'b1, 0};
    tbl[6]  = '{66,  1'b0, 1'b1, 0};
    tbl[7]  = '{82,  1'b0, 1'b1, 0};
    tbl[8]  = '{98,  1'b1, 1'b1, 0};
    tbl[9]  = '{114, 1'b0, 1'b1, 0};
    tbl[10] = '{130, 1'b1, 1'b1, 0};
    tbl[11] = '{146, 1'b1, 1'b1, 0};
    tbl[12] = '{161, 1'b1, 1'b1, 0};
    tbl[13] = '{162, 1'b1, 1'b0, 0};

    // Reset values and no spurious capture with busy_in held low.
    do_reset();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (100) step();
    chk("idle_fifo_count", 32'(fifo_count), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);

    // Single capture of 8'hA5 against the timing table.
    busy_in = 1'b1;
    step();
    num_in  = 8'hA5;
    busy_in = 1'b0;
    for (int r = 1; r <= 162; r++) begin
      step();
      busy_in = 1'b1;
      for (int k = 0; k < 14; k++) begin
        if (tbl[k].rel == r) begin
          chk("tbl_tx", 32'(tx), 32'(tbl[k].tx));
          chk("tbl_tx_busy", 32'(tx_busy), 32'(tbl[k].busy));
          chk("tbl_fifo_count", 32'(fifo_count), 32'(tbl[k].cnt));
        end
      end
    end
    exp_rx.push_back(8'hA5);
    drain();
    check_rx("single");

    // Burst of four captures two cycles apart.
    peak = 0;
    cap_byte(8'h01);
    cap_byte(8'h02);
    cap_byte(8'h04);
    cap_byte(8'h80);
    exp_rx = '{8'h01, 8'h02, 8'h04, 8'h80};
    drain();
    chk("burst_peak", 32'(peak), 32'd3);
    chk("burst_overflow", 32'(overflow), 32'd0);
    check_rx("burst");

    // Full FIFO with a capture landing in the IDLE pop cycle is accepted.
    for (int i = 0; i < 5; i++) begin
      v = DW'($urandom);
      cap_byte(v);
      exp_rx.push_back(v);
    end
    busy_in = 1'b1;
    n = 0;
    while (m_cyc != m_start + FRAME && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("collide_wait", 32'(n < 2 * FRAME), 32'd1);
    chk("collide_full", 32'(fifo_count), 32'(DEPTH));
    v       = DW'($urandom);
    num_in  = v;
    busy_in = 1'b0;
    exp_rx.push_back(v);
    step();
    chk("collide_count", 32'(fifo_count), 32'(DEPTH));
    chk("collide_overflow", 32'(overflow), 32'd0);
    drain();
    check_rx("collide");

    // Overflow: six captures while the first frame transmits.
    for (int i = 0; i < 6; i++) begin
      v = DW'(8'h30 + i);
      cap_byte(v);
      if (i < 5) exp_rx.push_back(v);
    end
    step();
    chk("ovf_set", 32'(overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    check_rx("overflow");

    // Reset asserted mid-DATA takes effect without a clock edge.
    cap_byte(8'h5A);
    cap_byte(8'hC3);
    cap_byte(8'h3C);
    busy_in = 1'b1;
    n = 0;
    while (!(m_active(m_cyc) && (m_cyc - m_start) == 3 * CPB + 5) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("mid_data_wait", 32'(n < 2 * FRAME), 32'd1);
    chk("pre_rst_tx_busy", 32'(tx_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("async_rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
    do_reset();

    // Wrap-around: ten frames, each after the previous completes.
    for (int i = 0; i < 10; i++) begin
      v = DW'($urandom);
      cap_byte(v);
      exp_rx.push_back(v);
      drain();
    end
    check_rx("wrap");

    // Dense random captures: overflow and pop collisions are likely.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      busy_in = ($urandom_range(0, 99) < 60);
      num_in  = DW'($urandom);
      step();
    end
    drain();
    exp_rx = m_sent;
    check_rx("rand_dense");

    // Sparse random captures.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      busy_in = ($urandom_range(0, 149) != 0);
      num_in  = DW'($urandom);
      step();
    end
    drain();
    exp_rx = m_sent;
    check_rx("rand_sparse");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
